// File: rtl/blit_pixel_unit.sv
// blit_pixel_unit: two-stage pipeline (X, OUT) that turns blit source beats into 8-bit pixel writes.
// Stage X selects the byte and colours it; dropped beats still occupy their slot but never reach OUT.
module blit_pixel_unit #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_dst_address,
    input  logic [ADDR_W-1:0] in_src_address,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_mode,
    input  logic [2:0]        in_bit_index,
    input  logic [7:0]        reg_color,
    input  logic [7:0]        reg_bgcolor,
    input  logic [8:0]        transparent_color,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_address,
    output logic [7:0]        out_wdata,
    output logic              busy,
    output logic [CNT_W-1:0]  pixels_written
);
    localparam int LB = $clog2(DATA_W / 8);

    logic              x_valid_q, x_valid_d;
    logic [ADDR_W-1:0] x_dst_q, x_dst_d;
    logic [LB-1:0]     x_lane_q, x_lane_d;
    logic [DATA_W-1:0] x_data_q, x_data_d;
    logic [1:0]        x_mode_q, x_mode_d;
    logic [2:0]        x_bit_q, x_bit_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_address_q, out_address_d;
    logic [7:0]        out_wdata_q, out_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall, glyph, drop;
    logic [7:0]        lane_byte, pixel;
    logic              src_unused;

    // only the byte-lane bits of the source address matter here
    assign src_unused = ^in_src_address[ADDR_W-1:LB];

    always_comb begin
        stall         = out_valid_q & ~out_ready;
        in_ready      = ~stall;
        busy          = x_valid_q | out_valid_q;
        x_valid_d     = stall ? x_valid_q : in_valid;
        x_dst_d       = stall ? x_dst_q : in_dst_address;
        x_lane_d      = stall ? x_lane_q : in_src_address[LB-1:0];
        x_data_d      = stall ? x_data_q : in_data;
        x_mode_d      = stall ? x_mode_q : in_mode;
        x_bit_d       = stall ? x_bit_q : in_bit_index;
        lane_byte     = (x_mode_q == 2'b00) ? x_data_q[7:0] : x_data_q[{x_lane_q, 3'b000} +: 8];
        glyph         = lane_byte[3'd7 - x_bit_q];
        pixel         = x_mode_q[1] ? (glyph ? reg_color : reg_bgcolor) : lane_byte;
        drop          = (~transparent_color[8] & ({1'b0, pixel} == transparent_color)) |
                        ((x_mode_q == 2'b11) & ~glyph);
        out_valid_d   = stall ? out_valid_q : x_valid_q & ~drop;
        out_address_d = stall ? out_address_q : x_dst_q;
        out_wdata_d   = stall ? out_wdata_q : pixel;
        cnt_d         = (out_valid_q & out_ready) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_valid_q     <= 1'b0;
            x_dst_q       <= '0;
            x_lane_q      <= '0;
            x_data_q      <= '0;
            x_mode_q      <= '0;
            x_bit_q       <= '0;
            out_valid_q   <= 1'b0;
            out_address_q <= '0;
            out_wdata_q   <= '0;
            cnt_q         <= '0;
        end else begin
            x_valid_q     <= x_valid_d;
            x_dst_q       <= x_dst_d;
            x_lane_q      <= x_lane_d;
            x_data_q      <= x_data_d;
            x_mode_q      <= x_mode_d;
            x_bit_q       <= x_bit_d;
            out_valid_q   <= out_valid_d;
            out_address_q <= out_address_d;
            out_wdata_q   <= out_wdata_d;
            cnt_q         <= cnt_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_address    = out_address_q;
    assign out_wdata      = out_wdata_q;
    assign pixels_written = cnt_q;
endmodule

// File: tb/tb_blit_pixel_unit.sv
// tb_blit_pixel_unit: directed and randomized checks of blit_pixel_unit against a queue-based pixel model.
module tb_blit_pixel_unit;
    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 24;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_dst_address = '0;
    logic [ADDR_W-1:0] in_src_address = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic [1:0]        in_mode = '0;
    logic [2:0]        in_bit_index = '0;
    logic [7:0]        reg_color = '0;
    logic [7:0]        reg_bgcolor = '0;
    logic [8:0]        transparent_color = 9'h100;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ADDR_W-1:0] out_address;
    logic [7:0]        out_wdata;
    logic              busy;
    logic [CNT_W-1:0]  pixels_written;

    blit_pixel_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_dst_address(in_dst_address), .in_src_address(in_src_address), .in_data(in_data),
        .in_mode(in_mode), .in_bit_index(in_bit_index), .reg_color(reg_color),
        .reg_bgcolor(reg_bgcolor), .transparent_color(transparent_color),
        .out_valid(out_valid), .out_ready(out_ready), .out_address(out_address),
        .out_wdata(out_wdata), .busy(busy), .pixels_written(pixels_written)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int n_exp   = 0;
    int n_acc   = 0;
    logic [ADDR_W+7:0] q[$];
    bit                stalled_prev = 0;
    logic [ADDR_W-1:0] prev_addr;
    logic [7:0]        prev_data;
    logic              prev_valid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] m, input logic [DATA_W-1:0] d,
                                  input logic [ADDR_W-1:0] s, input logic [2:0] b,
                                  output bit drop, output logic [7:0] pix);
        int lane;
        int v;
        int g;
        lane = (m == 2'd0) ? 0 : int'(s) % (DATA_W / 8);
        v    = int'((d >> (8 * lane)) & 'hFF);
        g    = (v >> (7 - int'(b))) & 1;
        pix  = (m >= 2'd2) ? ((g != 0) ? reg_color : reg_bgcolor) : 8'(v);
        drop = (!transparent_color[8] && transparent_color[7:0] == pix) || (m == 2'd3 && g == 0);
    endfunction

    task automatic tick(input bit v, input logic [1:0] m, input logic [DATA_W-1:0] d,
                        input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] a,
                        input logic [2:0] b, input bit r);
        bit drop;
        logic [7:0] pix;
        logic [ADDR_W+7:0] e;
        @(negedge clock);
        in_valid = v; in_mode = m; in_data = d; in_src_address = s;
        in_dst_address = a; in_bit_index = b; out_ready = r;
        #1;
        if (!reset) begin
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (stalled_prev) begin
                chk("hold_valid", out_valid, prev_valid);
                chk("hold_addr", out_address, prev_addr);
                chk("hold_data", out_wdata, prev_data);
            end
            if (out_valid && out_ready) begin
                chk("beat_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("out_addr", out_address, e[ADDR_W+7:8]);
                    chk("out_wdata", out_wdata, e[7:0]);
                    n_exp++;
                end
            end
            if (v && in_ready) begin
                n_acc++;
                model(m, d, s, b, drop, pix);
                if (!drop) q.push_back({a, pix});
            end
            stalled_prev = out_valid && !out_ready;
            prev_valid = out_valid; prev_addr = out_address; prev_data = out_wdata;
        end else stalled_prev = 0;
    endtask

    task automatic idle();
        tick(0, 2'd0, '0, '0, '0, 3'd0, 1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (q.size() != 0 || busy); i++) idle();
        chk({tag, "_queue_empty"}, q.size(), 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pixels"}, pixels_written, n_exp & 'hFFFFFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pixels", pixels_written, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", out_address, 0);
        chk("rst_wdata", out_wdata, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clock);
        reset = 0;

        // copy, two-cycle latency
        tick(1, 2'd1, 32'hAABBCCDD, 26'h2, 26'h100, 3'd0, 1);
        idle();
        chk("copy_lat1_valid", out_valid, 0);
        idle();
        chk("copy_valid", out_valid, 1);
        chk("copy_wdata", out_wdata, 8'hBB);
        chk("copy_addr", out_address, 26'h100);
        chk("copy_cnt_before", pixels_written, 0);
        idle();
        chk("copy_cnt", pixels_written, 1);
        drain("copy");

        // text then text-keyed
        reg_color = 8'h1F; reg_bgcolor = 8'h02;
        tick(1, 2'd2, 32'h80, 26'h0, 26'h200, 3'd0, 1);
        tick(1, 2'd2, 32'h80, 26'h0, 26'h201, 3'd1, 1);
        idle();
        chk("text_fg_valid", out_valid, 1);
        chk("text_fg", out_wdata, 8'h1F);
        idle();
        chk("text_bg_valid", out_valid, 1);
        chk("text_bg", out_wdata, 8'h02);
        drain("text");
        tick(1, 2'd3, 32'h80, 26'h0, 26'h210, 3'd0, 1);
        tick(1, 2'd3, 32'h80, 26'h0, 26'h211, 3'd1, 1);
        idle();
        chk("tkey_fg", out_wdata, 8'h1F);
        idle();
        chk("tkey_bg_dropped", out_valid, 0);
        drain("tkey");

        // keying applies to the current beat
        transparent_color = 9'h000;
        tick(1, 2'd1, 32'h00, 26'h0, 26'h300, 3'd0, 1);
        tick(1, 2'd1, 32'h05, 26'h0, 26'h301, 3'd0, 1);
        tick(1, 2'd1, 32'h00, 26'h0, 26'h302, 3'd0, 1);
        chk("key_first_dropped", out_valid, 0);
        idle();
        chk("key_mid_valid", out_valid, 1);
        chk("key_mid_data", out_wdata, 8'h05);
        idle();
        chk("key_last_dropped", out_valid, 0);
        drain("key");

        // backpressure with ready pattern 1,0,0,1
        transparent_color = 9'h100;
        n_acc = 0;
        for (int k = 0; k < 100 && n_acc < 8; k++)
            tick(1, 2'd1, $urandom, 26'($urandom), 26'($urandom), 3'd0, (k % 4 == 0) || (k % 4 == 3));
        chk("bp_accepted", n_acc, 8);
        drain("bp");

        // randomized phases
        for (int p = 0; p < 6; p++) begin
            reg_color = 8'($urandom_range(0, 3)); reg_bgcolor = 8'($urandom);
            transparent_color = ($urandom_range(0, 2) == 0) ? 9'h100 : {1'b0, 8'($urandom_range(0, 3))};
            for (int k = 0; k < 300; k++)
                tick($urandom_range(0, 9) < 7, 2'($urandom),
                     $urandom_range(0, 1) ? $urandom : {6'd0, 2'($urandom), 6'd0, 2'($urandom), 6'd0, 2'($urandom), 6'd0, 2'($urandom)},
                     26'($urandom), 26'($urandom), 3'($urandom), $urandom_range(0, 9) < 6);
            drain("rand");
        end

        // reset mid-burst with two beats in flight
        transparent_color = 9'h100;
        tick(1, 2'd1, 32'h11, 26'h0, 26'h400, 3'd0, 1);
        tick(1, 2'd1, 32'h22, 26'h0, 26'h401, 3'd0, 1);
        tick(0, 2'd0, '0, '0, '0, 3'd0, 0);
        chk("mid_pre_valid", out_valid, 1);
        chk("mid_pre_busy", busy, 1);
        #2 reset = 1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pixels", pixels_written, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        q.delete();
        n_exp = 0;
        idle();
        @(negedge clock);
        reset = 0;
        repeat (6) begin
            idle();
            chk("mid_no_beat", out_valid, 0);
        end
        drain("mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/blit_pixel_unit.md
BLIT_PIXEL_UNIT -- requirements
Module: blit_pixel_unit

Interface
REQ-001 Parameter ADDR_W, default 26, SHALL set the width of all pixel addresses.
REQ-002 Parameter DATA_W, default 32, SHALL set the memory word width; legal values are 32, 64 and 128.
REQ-003 Parameter CNT_W, default 24, SHALL set the width of pixels_written.
REQ-004 clock  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  SHALL be asynchronous and active-high.
REQ-006 in_valid  in  1  marks an input beat; in_ready  out  1  marks that the beat is accepted.
REQ-007 in_dst_address  in  ADDR_W  is the destination address.
REQ-008 in_src_address  in  ADDR_W  is the source address; its low log2(DATA_W/8) bits SHALL select the byte.
REQ-009 in_data  in  DATA_W  is the source word.
REQ-010 in_mode  in  2  selects the mode: 00 solid, 01 copy, 10 text, 11 text-keyed.
REQ-011 in_bit_index  in  3  is the glyph bit index, with 0 as the MSB of the byte.
REQ-012 reg_color, reg_bgcolor  in  8 each  are the foreground and background colours.
REQ-013 transparent_color  in  9  is the colour key; bit 8 set SHALL disable keying.
REQ-014 out_valid  out  1 and out_ready  in  1  form the write handshake.
REQ-015 out_address  out  ADDR_W and out_wdata  out  8  carry the write beat.
REQ-016 busy  out  1  SHALL be high whenever any pipeline stage holds a valid beat.
REQ-017 pixels_written  out  CNT_W  counts completed out handshakes.

Function
REQ-018 The pipeline SHALL have two register stages (X, then OUT), giving 2-cycle latency from the in handshake to out_valid when unstalled.
REQ-019 stall = out_valid & ~out_ready; when stall=1, in_ready SHALL be 0 and both stages SHALL hold their contents.
REQ-020 Byte select SHALL be performed in stage X from the registered data:
- solid mode: byte = data[7:0]
- other modes: byte = byte lane src_address[log2(DATA_W/8)-1:0]
REQ-021 Pixel per mode:
- solid and copy: pixel = byte
- text and text-keyed: pixel = byte[7-bit_index] ? reg_color : reg_bgcolor
REQ-022 The beat SHALL be dropped (OUT not loaded valid) when either:
- keying is enabled and {1'b0,pixel} equals transparent_color, compared against the same beat's pixel
- mode is text-keyed and the glyph bit is 0
REQ-023 A dropped beat SHALL still consume its pipeline slot and SHALL NOT increment pixels_written.
REQ-024 The OUT stage SHALL load out_valid, out_address and out_wdata only when stall=0.
REQ-025 OUT outputs SHALL stay stable while stall=1.
REQ-026 pixels_written SHALL increment by 1 on each cycle with out_valid & out_ready, and SHALL wrap to 0 after all-ones.
REQ-027 reg_color, reg_bgcolor and transparent_color SHALL be sampled in stage X, i.e. the cycle the beat leaves X.
REQ-028 Simultaneous out handshake and a new in beat SHALL both complete in the same cycle, so full throughput is 1 pixel/cycle.
REQ-029 in_mode 11 with DATA_W=32 SHALL use the same byte select as copy and text.

Reset
REQ-030 While reset is high:
- out_valid=0, pixels_written=0, busy=0
- out_address=0, out_wdata=0
- all stage valid flags SHALL clear
REQ-031 Assertion of reset mid-transfer SHALL discard all in-flight beats without emitting them.
REQ-032 in_ready SHALL be 1 during and after reset.

Verification
REQ-033 Copy: DATA_W=32, mode 01, data=0xAABBCCDD, src[1:0]=2, dst=0x100, keying off, out_ready=1 -> out_valid two cycles later with out_wdata=0xBB, out_address=0x100, pixels_written=1.
REQ-034 Text: mode 10, byte 0x80, bit_index 0 then 1, color=0x1F, bg=0x02 -> outputs 0x1F then 0x02 on consecutive cycles.
REQ-035 Text-keyed: the same stimulus in mode 11 -> only 0x1F is emitted and pixels_written=1.
REQ-036 Keying: transparent_color=0x000, copy beats with bytes 0x00, 0x05, 0x00 -> a single beat 0x05 is emitted, and the key applies to the current beat rather than the previous one.
REQ-037 Backpressure: stream 8 beats while out_ready toggles 1,0,0,1,... ->
- no loss or duplication, order preserved
- in_ready=0 exactly while stall=1
- out outputs stable during stall
- pixels_written=8 at the end
REQ-038 Reset mid-burst: assert reset with 2 beats in flight -> out_valid=0 immediately (asynchronous), pixels_written=0, no further beats appear after release.
